// File: rtl/rst_sched.sv
// rst_sched: reset request scheduler for the SoC reset path.
// Gathers software resets, watchdog timeouts and bad kicks into one
// fixed-width soft_rst_en pulse, logs the reset cause in a register that
// only power-on/hard reset touches, and exposes a small register bank.
module rst_sched #(
    parameter int HOLDOFF_CYC = 4,   // must be >= 1
    parameter int PULSE_CYC   = 8,   // must be >= 1
    parameter int WDT_W       = 32   // 1..32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        re,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        jtag_rst_en,
    input  logic        sys_rst_n,
    output logic        soft_rst_en,
    output logic        wdt_irq
);

    localparam logic [31:0] KICK_KEY   = 32'hA5A5_5A5A;
    localparam logic [31:0] SWRST_KEY  = 32'h5AFE_0001;
    localparam logic [2:0]  A_CTRL     = 3'd0;
    localparam logic [2:0]  A_LOAD     = 3'd1;
    localparam logic [2:0]  A_KICK     = 3'd2;
    localparam logic [2:0]  A_SWRST    = 3'd3;
    localparam logic [2:0]  A_CAUSE    = 3'd4;
    localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_CYC - 1);
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYC - 1);
    localparam logic [WDT_W-1:0] CNT_ONE = {{(WDT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, HOLDOFF, PULSE, WAIT_REL} state_t;

    state_t           state;
    logic [15:0]      seq_cnt;
    logic             seen_low;
    logic             wdt_en;
    logic             wdt_rst_en;
    logic [WDT_W-1:0] wdt_load;
    logic [WDT_W-1:0] wdt_cnt;
    logic [4:0]       cause;       // {jtag, bad_kick, wdt, soft, por}
    logic             jtag_q;

    logic        wr_ctrl, wr_load, wr_kick, wr_swrst, wr_cause;
    logic        kick_good, kick_bad, sw_req;
    logic        counting, timeout, wdt_req, any_req, jtag_rise;
    logic        pulse_start;
    logic [4:0]  req_bits, set_bits, clr_bits;
    logic [31:0] rd_mux;

    assign wr_ctrl  = we && (addr == A_CTRL);
    assign wr_load  = we && (addr == A_LOAD);
    assign wr_kick  = we && (addr == A_KICK);
    assign wr_swrst = we && (addr == A_SWRST);
    assign wr_cause = we && (addr == A_CAUSE);

    assign kick_good = wr_kick && (wdata == KICK_KEY);
    assign kick_bad  = wr_kick && (wdata != KICK_KEY) && wdt_en;
    assign sw_req    = wr_swrst && (wdata == SWRST_KEY);

    // A good kick landing on the zero count wins, so a timely kick never trips.
    assign counting = wdt_en && (state == IDLE);
    assign timeout  = counting && !kick_good && (wdt_cnt == '0);
    assign wdt_req  = timeout && wdt_rst_en;

    assign jtag_rise = jtag_rst_en && !jtag_q;
    assign req_bits  = {1'b0, kick_bad, wdt_req, sw_req, 1'b0};
    assign set_bits  = req_bits | {jtag_rise, 4'b0000};
    assign clr_bits  = wr_cause ? wdata[4:0] : 5'b00000;
    assign any_req   = |req_bits;

    assign pulse_start = (state == HOLDOFF) && (seq_cnt == HOLD_LAST);

    // Read data selection; write-only and reserved words read as zero.
    always_comb begin
        rd_mux = 32'h0;
        case (addr)
            A_CTRL:  rd_mux = {30'h0, wdt_rst_en, wdt_en};
            A_LOAD:  rd_mux = 32'(wdt_load);
            A_CAUSE: rd_mux = {27'h0, cause};
            default: rd_mux = 32'h0;
        endcase
    end

    // Registered read port: data only in the cycle after a read strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= 32'h0;
        end else begin
            rdata <= re ? rd_mux : 32'h0;
        end
    end

    // Reset sequence FSM: holdoff, fixed-width pulse, then wait for the
    // system reset to be seen asserted and released before accepting more.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            seq_cnt     <= 16'h0;
            seen_low    <= 1'b0;
            soft_rst_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= HOLDOFF;
                        seq_cnt  <= 16'h0;
                        seen_low <= 1'b0;
                    end
                end
                HOLDOFF: begin
                    if (seq_cnt == HOLD_LAST) begin
                        state       <= PULSE;
                        seq_cnt     <= 16'h0;
                        soft_rst_en <= 1'b1;
                    end else begin
                        seq_cnt <= seq_cnt + 16'd1;
                    end
                end
                PULSE: begin
                    if (!sys_rst_n) begin
                        seen_low <= 1'b1;
                    end
                    if (seq_cnt == PULSE_LAST) begin
                        state       <= WAIT_REL;
                        seq_cnt     <= 16'h0;
                        soft_rst_en <= 1'b0;
                    end else begin
                        seq_cnt <= seq_cnt + 16'd1;
                    end
                end
                WAIT_REL: begin
                    if (!sys_rst_n) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Watchdog control, counter and interrupt; all cleared when a pulse starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_en     <= 1'b0;
            wdt_rst_en <= 1'b0;
            wdt_load   <= '1;
            wdt_cnt    <= '1;
            wdt_irq    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                wdt_en     <= wdata[0];
                wdt_rst_en <= wdata[1];
            end
            if (wr_load) begin
                wdt_load <= wdata[WDT_W-1:0];
            end
            if (wr_ctrl && wdata[0] && !wdt_en) begin
                wdt_cnt <= wdt_load;
            end else if (kick_good) begin
                wdt_cnt <= wdt_load;
            end else if (counting) begin
                wdt_cnt <= (wdt_cnt == '0) ? wdt_load : (wdt_cnt - CNT_ONE);
            end
            if (timeout) begin
                wdt_irq <= 1'b1;
            end
            if (wr_ctrl && wdata[2]) begin
                wdt_irq <= 1'b0;
            end
            if (pulse_start) begin
                wdt_en     <= 1'b0;
                wdt_rst_en <= 1'b0;
                wdt_irq    <= 1'b0;
            end
        end
    end

    // Cause log: a request accepted in IDLE replaces the log, anything else
    // accumulates; sets beat write-1-to-clear on the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause  <= 5'b00001;
            jtag_q <= 1'b0;
        end else begin
            jtag_q <= jtag_rst_en;
            if ((state == IDLE) && any_req) begin
                cause <= set_bits;
            end else begin
                cause <= (cause & ~clr_bits) | set_bits;
            end
        end
    end

endmodule

// File: tb/tb_rst_sched.sv
// tb_rst_sched: directed self-checking bench for rst_sched with
// hand-computed expectations for pulse timing, watchdog and cause logging.
module tb_rst_sched;

    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_LOAD  = 3'd1;
    localparam logic [2:0] A_KICK  = 3'd2;
    localparam logic [2:0] A_SWRST = 3'd3;
    localparam logic [2:0] A_CAUSE = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        re;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        jtag_rst_en;
    logic        sys_rst_n;
    logic        soft_rst_en;
    logic        wdt_irq;

    int checks   = 0;
    int failures = 0;

    rst_sched #(
        .HOLDOFF_CYC(4),
        .PULSE_CYC  (8),
        .WDT_W      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .re         (re),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .jtag_rst_en(jtag_rst_en),
        .sys_rst_n  (sys_rst_n),
        .soft_rst_en(soft_rst_en),
        .wdt_irq    (wdt_irq)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Advance n clock edges; inputs change and outputs are sampled 1 after the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_write(input logic [2:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick(1);
        we    = 1'b0;
        wdata = 32'h0;
    endtask

    task automatic apply_read(input logic [2:0] a, output logic [31:0] d);
        re   = 1'b1;
        addr = a;
        tick(1);
        re   = 1'b0;
        d    = rdata;
    endtask

    // Index 0 is the current cycle; reports first high index and high count.
    task automatic measure_pulse(input int window, output int first, output int count);
        first = -1;
        count = 0;
        for (int i = 0; i < window; i++) begin
            if (soft_rst_en) begin
                if (first < 0) first = i;
                count++;
            end
            tick(1);
        end
    endtask

    // Emulate the reset generator: pull sys_rst_n low, then release.
    task automatic release_sys_reset();
        sys_rst_n = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        tick(2);
    endtask

    logic [31:0] d;
    int          first;
    int          count;
    int          bad;

    initial begin
        rst         = 1'b1;
        we          = 1'b0;
        re          = 1'b0;
        addr        = 3'd0;
        wdata       = 32'h0;
        jtag_rst_en = 1'b0;
        sys_rst_n   = 1'b1;
        tick(3);
        rst = 1'b0;

        $display("[TB] reset state");
        check_output("rst_rdata", rdata, 32'h0);
        check_output("rst_soft", {31'h0, soft_rst_en}, 32'h0);
        check_output("rst_irq", {31'h0, wdt_irq}, 32'h0);
        apply_read(A_CAUSE, d);
        check_output("rst_cause", d, 32'h1);
        apply_read(A_CTRL, d);
        check_output("rst_ctrl", d, 32'h0);
        apply_read(A_LOAD, d);
        check_output("rst_load", d, 32'hFFFF_FFFF);
        tick(1);
        check_output("rdata_idle_zero", rdata, 32'h0);

        $display("[TB] software reset");
        apply_write(A_SWRST, 32'h5AFE_0001);
        measure_pulse(16, first, count);
        check_output("sw_pulse_start", 32'(first), 32'd4);
        check_output("sw_pulse_len", 32'(count), 32'd8);
        apply_write(A_SWRST, 32'h5AFE_0001);
        measure_pulse(16, first, count);
        check_output("wait_rel_drop", 32'(count), 32'd0);
        release_sys_reset();
        apply_read(A_CAUSE, d);
        check_output("sw_cause", d, 32'h2);
        apply_read(A_CTRL, d);
        check_output("sw_ctrl", d, 32'h0);
        apply_read(3'd6, d);
        check_output("reserved_read", d, 32'h0);
        apply_read(A_SWRST, d);
        check_output("swrst_read", d, 32'h0);

        $display("[TB] bad software key");
        apply_write(A_SWRST, 32'h5AFE_0002);
        measure_pulse(16, first, count);
        check_output("badkey_no_pulse", 32'(count), 32'd0);
        apply_read(A_CAUSE, d);
        check_output("badkey_cause", d, 32'h2);
        apply_write(A_CAUSE, 32'h2);
        apply_read(A_CAUSE, d);
        check_output("cause_w1c", d, 32'h0);

        $display("[TB] watchdog timeout reset");
        we    = 1'b1;
        re    = 1'b1;
        addr  = A_LOAD;
        wdata = 32'd20;
        tick(1);
        we    = 1'b0;
        re    = 1'b0;
        check_output("rw_same_cycle_old", rdata, 32'hFFFF_FFFF);
        apply_write(A_CTRL, 32'h3);
        first = -1;
        count = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 20) check_output("wdt_irq_before", {31'h0, wdt_irq}, 32'h0);
            if (i == 21) check_output("wdt_irq_rise", {31'h0, wdt_irq}, 32'h1);
            if (i == 26) check_output("wdt_irq_pulse_clr", {31'h0, wdt_irq}, 32'h0);
            if (soft_rst_en) begin
                if (first < 0) first = i;
                count++;
            end
            tick(1);
        end
        check_output("wdt_pulse_start", 32'(first), 32'd25);
        check_output("wdt_pulse_len", 32'(count), 32'd8);
        release_sys_reset();
        apply_read(A_CAUSE, d);
        check_output("wdt_cause", d, 32'h4);
        apply_read(A_CTRL, d);
        check_output("wdt_ctrl_cleared", d, 32'h0);
        apply_read(A_LOAD, d);
        check_output("wdt_load_read", d, 32'd20);

        $display("[TB] kicked watchdog then bad kick");
        apply_write(A_LOAD, 32'd20);
        apply_write(A_CTRL, 32'h1);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 12; j++) begin
                if (soft_rst_en || wdt_irq) bad++;
                tick(1);
            end
            apply_write(A_KICK, 32'hA5A5_5A5A);
        end
        check_output("kick_no_timeout", 32'(bad), 32'd0);
        apply_write(A_KICK, 32'h0000_1234);
        measure_pulse(16, first, count);
        check_output("badkick_pulse_start", 32'(first), 32'd4);
        check_output("badkick_pulse_len", 32'(count), 32'd8);
        release_sys_reset();
        apply_read(A_CAUSE, d);
        check_output("badkick_cause", d, 32'h8);

        $display("[TB] watchdog interrupt only");
        apply_write(A_LOAD, 32'd5);
        apply_write(A_CTRL, 32'h1);
        measure_pulse(12, first, count);
        check_output("irq_only_no_pulse", 32'(count), 32'd0);
        check_output("irq_only_set", {31'h0, wdt_irq}, 32'h1);
        apply_read(A_CTRL, d);
        check_output("irq_only_ctrl", d, 32'h1);
        apply_read(A_CAUSE, d);
        check_output("irq_only_cause", d, 32'h8);
        apply_write(A_CTRL, 32'h5);
        check_output("irq_clr_next", {31'h0, wdt_irq}, 32'h0);
        apply_write(A_CTRL, 32'h4);
        tick(10);
        check_output("irq_stays_clr", {31'h0, wdt_irq}, 32'h0);

        $display("[TB] requests during pulse");
        apply_write(A_SWRST, 32'h5AFE_0001);
        tick(5);
        apply_write(A_SWRST, 32'h5AFE_0001);
        jtag_rst_en = 1'b1;
        tick(2);
        jtag_rst_en = 1'b0;
        measure_pulse(20, first, count);
        check_output("inpulse_rest_len", 32'(count), 32'd4);
        release_sys_reset();
        measure_pulse(20, first, count);
        check_output("inpulse_no_second", 32'(count), 32'd0);
        apply_read(A_CAUSE, d);
        check_output("inpulse_cause", d, 32'h12);

        $display("[TB] hard reset mid-pulse");
        apply_write(A_SWRST, 32'h5AFE_0001);
        tick(6);
        check_output("midpulse_high", {31'h0, soft_rst_en}, 32'h1);
        rst = 1'b1;
        tick(1);
        check_output("midpulse_rst_low", {31'h0, soft_rst_en}, 32'h0);
        rst = 1'b0;
        apply_read(A_CAUSE, d);
        check_output("midpulse_cause", d, 32'h1);
        measure_pulse(20, first, count);
        check_output("midpulse_no_resume", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
